memory_controller: RTL and testbench
====================================

// Module: memory_controller
// PURPOSE
//  Bus arbiter and snoop write-back sequencer between one CPU-side cache and an external (snooping) agent.
//  Grants the shared memory path to either the CPU or the external agent. CPU owns the bus until it drops its request.
//  On an external snoop hitting a MODIFIED line, flushes the line to main memory, downgrades the cache copy to SHARED,
//  then pulses release_EXT.
// PARAMETERS
//  LINE_W   66   cache line width = {mesi[1:0], data[63:0]}; mesi field at [LINE_W-1:LINE_W-2]
// PORTS
//  clk                         in   1       system clock, rising edge
//  reset                       in   1       asynchronous, active-low reset
//  req_CPU                     in   1       CPU bus request, level, held for whole transaction
//  req_EXT                     in   1       external agent bus/snoop request, level
//  read_line                   in   LINE_W  cache line currently addressed
//  address_wanted_from_memory  in   Taddress  line address of current transaction (passed through, not stored)
//  rd_mesi_state               in   Tmesi_state  MESI state of addressed line in CPU cache
//  read_mm_completed           in   1       main memory has finished the current write, 1-cycle pulse
//  write_line                  out  LINE_W  line driven to cache and main memory
//  we                          out  1       cache write enable (line state update)
//  we_to_mm                    out  1       main-memory write enable
//  gnt_CPU                     out  1       CPU granted
//  gnt_EXT                     out  1       external agent granted
//  release_EXT                 out  1       1-cycle pulse: snoop write-back done, external may proceed
// BEHAVIOUR
//  MESI encoding (Tmesi_state, 2 bits): I=00 S=01 E=10 M=11.
//  FSM current_state[1:0], registered; next_state is combinational: IDLE=00 CPU=01 EXT=10 WB=11.
//  reset low: current_state=IDLE, all outputs 0, write_line=0, immediately and independent of clk.
//  IDLE: req_CPU -> CPU; else req_EXT -> EXT; else stay. Both requests in the same cycle: CPU wins.
//  CPU: stay while req_CPU=1; req_EXT is ignored, no preemption. On req_CPU=0: req_EXT ? EXT : IDLE.
//  EXT: if rd_mesi_state==M -> WB. Else if req_EXT=0 -> (req_CPU ? CPU : IDLE). Else stay.
//  WB: we_to_mm=1 and write_line=read_line every cycle until read_mm_completed=1.
//    In the cycle read_mm_completed=1, next_state=EXT, and the following are registered for exactly 1 cycle:
//    we=1, write_line={S, read_line[63:0]}, release_EXT=1.
//    req_EXT dropping in WB does not abort; the flush always completes.
//  gnt_CPU = (current_state==CPU). gnt_EXT = (current_state==EXT || current_state==WB). Decoded from the registered state.
//  gnt_CPU and gnt_EXT are never 1 together. Grant appears in the cycle after the request is sampled (1-clk latency).
//  we, release_EXT: registered pulses, otherwise 0. we_to_mm is 0 outside WB.
//  Unreachable/illegal state encodings are not possible with 2 bits. Asynchronous reset mid-WB abandons the flush.
// TESTING
//  1 reset low 30ns -> state 00, gnt_CPU=gnt_EXT=we=we_to_mm=release_EXT=0; release reset, no reqs -> stays 00.
//  2 req_CPU=1, then req_EXT=1 while CPU held -> state 01, gnt_CPU=1, gnt_EXT=0 for every cycle CPU holds.
//  3 From 2, drop req_CPU with req_EXT=1 -> next edge state 10, gnt_EXT=1; then drop req_EXT -> state 00.
//  4 req_CPU=req_EXT=1 same cycle from IDLE -> state 01; gnt_EXT=0.
//  5 EXT granted, rd_mesi_state=11, read_line=66'h3_DEAD_BEEF_0123_4567
//    -> state 11, we_to_mm=1, write_line=read_line.
//    Pulse read_mm_completed -> next cycle we=1, release_EXT=1, write_line=66'h1_DEAD_BEEF_0123_4567, state 10.
//  6 Drop reset mid-WB -> outputs 0 asynchronously, state 00.

Source files
------------

// File: rtl/memory_controller.sv
// Bus arbiter between a CPU-side cache and an external snooping agent.
// A snoop that hits a MODIFIED line is written back to main memory and downgraded to SHARED before the agent is released.
module memory_controller #(
    parameter int unsigned LINE_W = 66,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_CPU,
    input  logic              req_EXT,
    input  logic [LINE_W-1:0] read_line,
    input  logic [ADDR_W-1:0] address_wanted_from_memory,
    input  logic [1:0]        rd_mesi_state,
    input  logic              read_mm_completed,
    output logic [LINE_W-1:0] write_line,
    output logic              we,
    output logic              we_to_mm,
    output logic              gnt_CPU,
    output logic              gnt_EXT,
    output logic              release_EXT
);

    localparam int unsigned DATA_W = LINE_W - 2;
    localparam logic [1:0]  MESI_S = 2'b01;
    localparam logic [1:0]  MESI_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_EXT  = 2'b10,
        ST_WB   = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_we;
    logic                w_we_to_mm;
    logic                w_release;
    logic [LINE_W-1:0]   w_write_line;
    logic [LINE_W-1:0]   r_write_line;
    logic                r_we;
    logic                r_we_to_mm;
    logic                r_gnt_cpu;
    logic                r_gnt_ext;
    logic                r_release;

    // The address only travels alongside the transaction; nothing here needs it.
    logic w_unused_addr;
    assign w_unused_addr = ^address_wanted_from_memory;

    // State register; outputs are registered from the next-state decode so they track the registered state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_write_line <= '0;
            r_we         <= 1'b0;
            r_we_to_mm   <= 1'b0;
            r_gnt_cpu    <= 1'b0;
            r_gnt_ext    <= 1'b0;
            r_release    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_write_line <= w_write_line;
            r_we         <= w_we;
            r_we_to_mm   <= w_we_to_mm;
            r_gnt_cpu    <= (w_next_state == ST_CPU);
            r_gnt_ext    <= (w_next_state == ST_EXT) || (w_next_state == ST_WB);
            r_release    <= w_release;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_we_to_mm   = 1'b0;
        w_release    = 1'b0;
        w_write_line = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_CPU) begin
                    w_next_state = ST_CPU;
                end else if (req_EXT) begin
                    w_next_state = ST_EXT;
                end
            end
            ST_CPU: begin
                // CPU keeps the bus until it lets go; no preemption.
                if (!req_CPU) begin
                    w_next_state = req_EXT ? ST_EXT : ST_IDLE;
                end
            end
            ST_EXT: begin
                if (rd_mesi_state == MESI_M) begin
                    w_next_state = ST_WB;
                    w_we_to_mm   = 1'b1;
                    w_write_line = read_line;
                end else if (!req_EXT) begin
                    w_next_state = req_CPU ? ST_CPU : ST_IDLE;
                end
            end
            ST_WB: begin
                // Flush runs to completion even if the snoop request is withdrawn.
                if (read_mm_completed) begin
                    w_next_state = ST_EXT;
                    w_we         = 1'b1;
                    w_release    = 1'b1;
                    w_write_line = {MESI_S, read_line[DATA_W-1:0]};
                end else begin
                    w_we_to_mm   = 1'b1;
                    w_write_line = read_line;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign write_line  = r_write_line;
    assign we          = r_we;
    assign we_to_mm    = r_we_to_mm;
    assign gnt_CPU     = r_gnt_cpu;
    assign gnt_EXT     = r_gnt_ext;
    assign release_EXT = r_release;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: arbitration, snoop write-back sequence and asynchronous reset.
module tb_memory_controller;

    localparam int unsigned LINE_W = 66;
    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              req_CPU;
    logic              req_EXT;
    logic [LINE_W-1:0] read_line;
    logic [ADDR_W-1:0] address_wanted_from_memory;
    logic [1:0]        rd_mesi_state;
    logic              read_mm_completed;
    logic [LINE_W-1:0] write_line;
    logic              we;
    logic              we_to_mm;
    logic              gnt_CPU;
    logic              gnt_EXT;
    logic              release_EXT;

    int n_tests = 0;
    int n_fail  = 0;

    memory_controller #(
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .req_CPU                    (req_CPU),
        .req_EXT                    (req_EXT),
        .read_line                  (read_line),
        .address_wanted_from_memory (address_wanted_from_memory),
        .rd_mesi_state              (rd_mesi_state),
        .read_mm_completed          (read_mm_completed),
        .write_line                 (write_line),
        .we                         (we),
        .we_to_mm                   (we_to_mm),
        .gnt_CPU                    (gnt_CPU),
        .gnt_EXT                    (gnt_EXT),
        .release_EXT                (release_EXT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset                      = 1'b0;
        req_CPU                    = 1'b0;
        req_EXT                    = 1'b0;
        read_line                  = '0;
        address_wanted_from_memory = 32'h0000_1000;
        rd_mesi_state              = 2'b00;
        read_mm_completed          = 1'b0;

        // 1: reset held low, then released with no requests
        #30;
        check("rst_state",    66'(dut.r_state), 66'h0);
        check("rst_gnt_cpu",  66'(gnt_CPU),     66'h0);
        check("rst_gnt_ext",  66'(gnt_EXT),     66'h0);
        check("rst_we",       66'(we),          66'h0);
        check("rst_we_to_mm", 66'(we_to_mm),    66'h0);
        check("rst_release",  66'(release_EXT), 66'h0);
        check("rst_wline",    write_line,       66'h0);
        reset = 1'b1;
        step();
        step();
        check("idle_state",   66'(dut.r_state), 66'h0);
        check("idle_gnt_cpu", 66'(gnt_CPU),     66'h0);

        // 2: CPU holds the bus, external request is ignored
        req_CPU = 1'b1;
        step();
        check("cpu_state",    66'(dut.r_state), 66'h1);
        check("cpu_gnt_cpu",  66'(gnt_CPU),     66'h1);
        check("cpu_gnt_ext",  66'(gnt_EXT),     66'h0);
        req_EXT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("cpu_hold_state", 66'(dut.r_state), 66'h1);
            check("cpu_hold_gcpu",  66'(gnt_CPU),     66'h1);
            check("cpu_hold_gext",  66'(gnt_EXT),     66'h0);
        end

        // 3: CPU lets go while external waits; then external lets go
        req_CPU = 1'b0;
        step();
        check("handoff_state", 66'(dut.r_state), 66'h2);
        check("handoff_gext",  66'(gnt_EXT),     66'h1);
        check("handoff_gcpu",  66'(gnt_CPU),     66'h0);
        req_EXT = 1'b0;
        step();
        check("ext_done_state", 66'(dut.r_state), 66'h0);
        check("ext_done_gext",  66'(gnt_EXT),     66'h0);

        // 4: simultaneous requests from IDLE, CPU wins
        req_CPU = 1'b1;
        req_EXT = 1'b1;
        step();
        check("tie_state", 66'(dut.r_state), 66'h1);
        check("tie_gext",  66'(gnt_EXT),     66'h0);
        check("tie_gcpu",  66'(gnt_CPU),     66'h1);
        req_CPU = 1'b0;
        req_EXT = 1'b0;
        step();
        check("tie_end_state", 66'(dut.r_state), 66'h0);

        // 5: snoop hits a MODIFIED line -> write-back, downgrade, release
        req_EXT       = 1'b1;
        rd_mesi_state = 2'b01;
        step();
        check("snoop_state",   66'(dut.r_state), 66'h2);
        check("snoop_s_wemm",  66'(we_to_mm),    66'h0);
        rd_mesi_state = 2'b11;
        read_line     = 66'h3_DEAD_BEEF_0123_4567;
        step();
        check("wb_state",   66'(dut.r_state), 66'h3);
        check("wb_we_mm",   66'(we_to_mm),    66'h1);
        check("wb_wline",   write_line,       66'h3_DEAD_BEEF_0123_4567);
        check("wb_gext",    66'(gnt_EXT),     66'h1);
        check("wb_we",      66'(we),          66'h0);
        check("wb_release", 66'(release_EXT), 66'h0);
        req_EXT = 1'b0;
        step();
        check("wb_hold_state", 66'(dut.r_state), 66'h3);
        check("wb_hold_we_mm", 66'(we_to_mm),    66'h1);
        read_mm_completed = 1'b1;
        step();
        check("wbdone_we",      66'(we),          66'h1);
        check("wbdone_release", 66'(release_EXT), 66'h1);
        check("wbdone_wline",   write_line,       66'h1_DEAD_BEEF_0123_4567);
        check("wbdone_state",   66'(dut.r_state), 66'h2);
        check("wbdone_we_mm",   66'(we_to_mm),    66'h0);
        read_mm_completed = 1'b0;
        rd_mesi_state     = 2'b01;
        step();
        check("post_we",      66'(we),          66'h0);
        check("post_release", 66'(release_EXT), 66'h0);
        check("post_state",   66'(dut.r_state), 66'h0);

        // 6: asynchronous reset in the middle of a write-back
        req_EXT       = 1'b1;
        rd_mesi_state = 2'b11;
        step();
        check("r6_ext_state", 66'(dut.r_state), 66'h2);
        step();
        check("r6_wb_state",  66'(dut.r_state), 66'h3);
        check("r6_wb_we_mm",  66'(we_to_mm),    66'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_state", 66'(dut.r_state), 66'h0);
        check("arst_we_mm", 66'(we_to_mm),    66'h0);
        check("arst_gext",  66'(gnt_EXT),     66'h0);
        check("arst_wline", write_line,       66'h0);
        req_EXT       = 1'b0;
        rd_mesi_state = 2'b00;
        step();
        reset = 1'b1;
        step();
        check("arst_after_state", 66'(dut.r_state), 66'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
